fport_tlm_scheduler: RTL and testbench
======================================

FPORT_TLM_SCHEDULER -- requirements
Module: fport_tlm_scheduler

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of telemetry requesters (2..8).
REQ-002 SHALL have parameter GAP_CYCLES, default 1600, clock cycles between poll and first transmitted byte (min 1).
REQ-003 SHALL have port clock  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pollValid  input  1  one-cycle pulse: decoder accepted an uplink poll frame.
REQ-006 SHALL have port req  input  NUM_SRC  per-source request; held high until granted.
REQ-007 SHALL have port srcAppId  input  NUM_SRC*16  flattened app IDs, source i at bits [16i+15:16i].
REQ-008 SHALL have port srcData  input  NUM_SRC*32  flattened payloads, source i at bits [32i+31:32i].
REQ-009 SHALL have port grant  output  NUM_SRC  one-hot, one-cycle pulse when the source's data is captured.
REQ-010 SHALL have port txData  output  8  byte offered to the UART transmitter.
REQ-011 SHALL have port txSend  output  1  valid; held until accepted.
REQ-012 SHALL have port txReady  input  1  UART ready; byte transferred on a cycle with txSend && txReady.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port frameSent  output  1  one-cycle pulse after the closing 0x7E is accepted.
REQ-015 SHALL have port pollDropped  output  1  one-cycle pulse when pollValid arrives while busy.

Function
REQ-016 SHALL implement states IDLE, GAP, LOAD, SEND, DONE.
REQ-017 IDLE->GAP on pollValid; GAP counter loads GAP_CYCLES-1, decrements each cycle, GAP->LOAD when it reaches 0.
REQ-018 LOAD (one cycle) SHALL select a winner among asserted req, pulse its grant bit, capture its srcAppId/srcData, and set prim=0x10; LOAD->SEND.
REQ-019 If no req is asserted in LOAD, SHALL capture appId=0, data=0, prim=0x00, and assert no grant.
REQ-020 Logical frame SHALL be 0x7E, 0x08, 0x01, prim, appId[7:0], appId[15:8], data[7:0], data[15:8], data[23:16], data[31:24], crc, 0x7E.
REQ-021 crc SHALL be 0xFF minus the 8-bit end-around-carry sum (on carry out: sum = low byte + 1) of the nine bytes 0x08..data[31:24], computed on unescaped values.
REQ-022 Every byte between the delimiters, crc included, equal to 0x7D or 0x7E SHALL be sent as 0x7D followed by byte XOR 0x20; delimiters are never escaped.
REQ-023 txData SHALL be stable while txSend is high and txReady is low; the next byte SHALL be offered the cycle after acceptance (no idle gap).
REQ-024 SEND->DONE on acceptance of the closing 0x7E; DONE pulses frameSent and returns to IDLE the next cycle.
REQ-025 pollValid in any state other than IDLE SHALL be ignored except for a pollDropped pulse; pollValid in the DONE cycle is dropped.
REQ-026 req changes after LOAD SHALL NOT affect the frame in flight.

Reset
REQ-027 On reset_n low, regardless of state (including mid-frame), SHALL asynchronously enter IDLE, abandon any frame, and clear txSend, grant, frameSent, pollDropped, busy to 0 and txData to 0x00.
REQ-028 The arbitration pointer SHALL reset to source 0 having highest priority.

Configuration
REQ-029 With FPORT_TLM_ROUND_ROBIN_EN defined, LOAD SHALL grant the first asserted req at or after (last granted index + 1) mod NUM_SRC; the pointer updates only when a grant issues.
REQ-030 Without FPORT_TLM_ROUND_ROBIN_EN, LOAD SHALL grant the lowest-index asserted req (fixed priority), with no pointer register.

Verification
REQ-031 Poll, req=0 -> after GAP_CYCLES, bytes 7E 08 01 00 00 00 00 00 00 00 F6 7E, no grant, one frameSent.
REQ-032 Poll, req[1]=1, appId1=0x0210, data1=0x000004B0 -> grant=0b0010 in LOAD; bytes 7E 08 01 10 10 02 B0 04 00 00 20 7E.
REQ-033 As REQ-032 with data1=0x0000007E -> bytes 7E 08 01 10 10 02 7D 5E 00 00 00 56 7E.
REQ-034 req=0b1111 held, four polls -> grant order 0,1,2,3 with FPORT_TLM_ROUND_ROBIN_EN, 0,0,0,0 without.
REQ-035 txReady toggled randomly -> txData stable while stalled, byte sequence unchanged; second poll mid-frame -> one pollDropped, frame uncorrupted.
REQ-036 reset_n low during the 5th byte -> txSend=0 immediately, IDLE; next poll yields a complete correct frame.

Source files
------------

// File: rtl/fport_tlm_scheduler.sv
// FPort telemetry scheduler: on an uplink poll, waits a gap, arbitrates requesters and sends one escaped frame.
// Optional FPORT_TLM_ROUND_ROBIN_EN selects round-robin arbitration (default: fixed priority, source 0 highest).
module fport_tlm_scheduler #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned GAP_CYCLES = 1600
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pollValid,
    input  logic [NUM_SRC-1:0]    req,
    input  logic [NUM_SRC*16-1:0] srcAppId,
    input  logic [NUM_SRC*32-1:0] srcData,
    output logic [NUM_SRC-1:0]    grant,
    output logic [7:0]            txData,
    output logic                  txSend,
    input  logic                  txReady,
    output logic                  busy,
    output logic                  frameSent,
    output logic                  pollDropped
);

    localparam int unsigned IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, GAP, LOAD, SEND, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] gap_cnt;
    logic [3:0]    byte_idx;
    logic          esc_phase;
    logic [15:0]   app_id;
    logic [31:0]   data;
    logic [7:0]    prim;

    logic [IW-1:0] start_idx, win_idx;
    logic          win_found;
    logic [IW:0]   cand;

    logic [71:0]   crc_bytes;
    logic [8:0]    crc_tmp;
    logic [7:0]    crc_sum, crc, raw;
    logic          needs_esc;

`ifdef FPORT_TLM_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr;
    assign start_idx = rr_ptr;
`else
    assign start_idx = '0;
`endif

    // First asserted request scanning upward from start_idx, wrapping at NUM_SRC.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cand = {1'b0, start_idx} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_SRC))
                cand = cand - (IW+1)'(NUM_SRC);
            if (!win_found && req[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        grant = '0;
        if (state == LOAD && win_found)
            grant[win_idx] = 1'b1;
    end

    // End-around-carry checksum over the nine unescaped body bytes.
    always_comb begin
        crc_bytes = {data, app_id, prim, 8'h01, 8'h08};
        crc_sum   = '0;
        crc_tmp   = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            crc_tmp = {1'b0, crc_sum} + {1'b0, crc_bytes[8*i +: 8]};
            crc_sum = crc_tmp[8] ? crc_tmp[7:0] + 8'd1 : crc_tmp[7:0];
        end
        crc = 8'hFF - crc_sum;
    end

    always_comb begin
        case (byte_idx)
            4'd0:    raw = 8'h7E;
            4'd1:    raw = 8'h08;
            4'd2:    raw = 8'h01;
            4'd3:    raw = prim;
            4'd4:    raw = app_id[7:0];
            4'd5:    raw = app_id[15:8];
            4'd6:    raw = data[7:0];
            4'd7:    raw = data[15:8];
            4'd8:    raw = data[23:16];
            4'd9:    raw = data[31:24];
            4'd10:   raw = crc;
            default: raw = 8'h7E;
        endcase
        needs_esc = (byte_idx != 4'd0) && (byte_idx != 4'd11) &&
                    (raw == 8'h7D || raw == 8'h7E);
    end

    always_comb begin
        txData = '0;
        if (state == SEND) begin
            if (esc_phase)
                txData = raw ^ 8'h20;
            else if (needs_esc)
                txData = 8'h7D;
            else
                txData = raw;
        end
    end

    assign txSend      = (state == SEND);
    assign busy        = (state != IDLE);
    assign frameSent   = (state == DONE);
    assign pollDropped = pollValid && (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (pollValid) state_nx = GAP;
            GAP:  if (gap_cnt == '0) state_nx = LOAD;
            LOAD: state_nx = SEND;
            SEND: if (txReady && byte_idx == 4'd11) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            byte_idx  <= '0;
            esc_phase <= 1'b0;
            app_id    <= '0;
            data      <= '0;
            prim      <= '0;
`ifdef FPORT_TLM_ROUND_ROBIN_EN
            rr_ptr    <= '0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (pollValid) gap_cnt <= CW'(GAP_CYCLES - 1);
                GAP:  if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                LOAD: begin
                    byte_idx  <= '0;
                    esc_phase <= 1'b0;
                    if (win_found) begin
                        app_id <= srcAppId[win_idx*16 +: 16];
                        data   <= srcData[win_idx*32 +: 32];
                        prim   <= 8'h10;
`ifdef FPORT_TLM_ROUND_ROBIN_EN
                        rr_ptr <= (win_idx == IW'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
`endif
                    end else begin
                        app_id <= '0;
                        data   <= '0;
                        prim   <= 8'h00;
                    end
                end
                SEND: if (txReady) begin
                    if (needs_esc && !esc_phase) begin
                        esc_phase <= 1'b1;
                    end else begin
                        esc_phase <= 1'b0;
                        byte_idx  <= byte_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fport_tlm_scheduler.sv
// Self-checking bench for fport_tlm_scheduler: directed frames, arbitration order, random stalls and reset abort.
module tb_fport_tlm_scheduler;

    localparam int unsigned NSRC = 4;
    localparam int unsigned GAP  = 6;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic                  pollValid;
    logic [NSRC-1:0]       req;
    logic [NSRC*16-1:0]    srcAppId;
    logic [NSRC*32-1:0]    srcData;
    logic [NSRC-1:0]       grant;
    logic [7:0]            txData;
    logic                  txSend;
    logic                  txReady;
    logic                  busy;
    logic                  frameSent;
    logic                  pollDropped;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int          model_last = NSRC - 1;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];

    fport_tlm_scheduler #(.NUM_SRC(NSRC), .GAP_CYCLES(GAP)) dut (
        .clock(clock), .reset_n(reset_n), .pollValid(pollValid), .req(req),
        .srcAppId(srcAppId), .srcData(srcData), .grant(grant), .txData(txData),
        .txSend(txSend), .txReady(txReady), .busy(busy), .frameSent(frameSent),
        .pollDropped(pollDropped)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int model_pick(input logic [NSRC-1:0] r);
        int s;
`ifdef FPORT_TLM_ROUND_ROBIN_EN
        s = (model_last + 1) % NSRC;
`else
        s = 0;
`endif
        for (int i = 0; i < NSRC; i++)
            if (r[(s + i) % NSRC]) return (s + i) % NSRC;
        return -1;
    endfunction

    // Expected wire bytes from the frame rules: body, ones'-complement style checksum, then byte stuffing.
    task automatic model_frame(input int pick);
        logic [7:0] body[10];
        logic [15:0] a;
        logic [31:0] d;
        int s;
        a = (pick >= 0) ? srcAppId[pick*16 +: 16] : 16'h0;
        d = (pick >= 0) ? srcData[pick*32 +: 32] : 32'h0;
        body = '{8'h08, 8'h01, (pick >= 0) ? 8'h10 : 8'h00, a[7:0], a[15:8],
                 d[7:0], d[15:8], d[23:16], d[31:24], 8'h00};
        s = 0;
        for (int i = 0; i < 9; i++) begin
            s = s + int'(body[i]);
            if (s > 255) s = s - 255;
        end
        body[9] = 8'(255 - s);
        exp_q = {8'h7E};
        for (int i = 0; i < 10; i++) begin
            if (body[i] == 8'h7D || body[i] == 8'h7E) begin
                exp_q.push_back(8'h7D);
                exp_q.push_back(body[i] ^ 8'h20);
            end else begin
                exp_q.push_back(body[i]);
            end
        end
        exp_q.push_back(8'h7E);
    endtask

    task automatic run_frame(input string tag, input bit rand_ready, input bit inject_poll,
                             input bit scramble, input logic [NSRC-1:0] exp_grant);
        int unsigned wait_cyc, gcount, drops, fsent;
        logic [NSRC-1:0] gseen;
        logic [7:0] held;
        bit stalled;
        got_q.delete();
        pollValid = 1'b1;
        step();
        pollValid = 1'b0;
        chk({tag, "_busy_poll"}, busy, 1);
        wait_cyc = 0; gcount = 0; gseen = '0;
        while (!txSend && wait_cyc < 4*GAP + 20) begin
            if (grant != '0) begin gcount++; gseen = grant; end
            step();
            wait_cyc++;
        end
        chk({tag, "_send_start"}, txSend, 1);
        chk({tag, "_gap_len"}, wait_cyc, GAP + 1);
        chk({tag, "_grant_cnt"}, gcount, (exp_grant != '0) ? 1 : 0);
        chk({tag, "_grant"}, gseen, exp_grant);
        if (scramble) begin
            req      = NSRC'($urandom);
            srcAppId = {$urandom, $urandom};
            srcData  = {$urandom, $urandom, $urandom, $urandom};
        end
        stalled = 1'b0; drops = 0; fsent = 0; held = '0;
        for (int c = 0; c < 400 && fsent == 0; c++) begin
            if (frameSent) begin
                fsent++;
            end else begin
                if (stalled) chk({tag, "_stall_hold"}, txData, held);
                txReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (inject_poll && got_q.size() == 3 && drops == 0) begin
                    pollValid = 1'b1;
                    #1;
                    chk({tag, "_poll_dropped"}, pollDropped, 1);
                    drops++;
                end
                if (txSend && txReady) got_q.push_back(txData);
                stalled = txSend && !txReady;
                held    = txData;
                step();
                pollValid = 1'b0;
            end
        end
        chk({tag, "_frame_sent"}, frameSent, 1);
        chk({tag, "_done_nosend"}, txSend, 0);
        step();
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_fs_pulse"}, frameSent, 0);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #12;
        @(negedge clock);
        reset_n = 1'b1;
        model_last = NSRC - 1;
        step();
    endtask

    initial begin
        int pick;
        int unsigned cnt;
        logic [NSRC-1:0] eg;
        reset_n = 1'b0; pollValid = 1'b0; req = '0; txReady = 1'b1;
        srcAppId = '0; srcData = '0;
        #12;
        chk("rst_txSend", txSend, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_txData", txData, 0);
        chk("rst_frameSent", frameSent, 0);
        chk("rst_pollDropped", pollDropped, 0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        exp_q = {8'h7E, 8'h08, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF6, 8'h7E};
        run_frame("noreq", 1'b0, 1'b0, 1'b0, '0);

        req = 4'b0010;
        srcAppId[31:16] = 16'h0210;
        srcData[63:32]  = 32'h0000_04B0;
        exp_q = {8'h7E, 8'h08, 8'h01, 8'h10, 8'h10, 8'h02, 8'hB0, 8'h04, 8'h00, 8'h00, 8'h20, 8'h7E};
        run_frame("src1", 1'b0, 1'b0, 1'b0, 4'b0010);
        model_last = 1;

        srcData[63:32] = 32'h0000_007E;
        exp_q = {8'h7E, 8'h08, 8'h01, 8'h10, 8'h10, 8'h02, 8'h7D, 8'h5E, 8'h00, 8'h00, 8'h00, 8'h56, 8'h7E};
        run_frame("esc", 1'b1, 1'b1, 1'b0, 4'b0010);
        model_last = 1;

        // Abort mid-frame while the fifth byte is on offer.
        srcData[63:32] = 32'h0000_04B0;
        pollValid = 1'b1;
        step();
        pollValid = 1'b0;
        txReady = 1'b1;
        cnt = 0;
        for (int c = 0; c < 4*GAP + 40 && cnt < 4; c++) begin
            if (txSend) cnt++;
            step();
        end
        chk("abort_byte5", txData, 8'h10);
        reset_n = 1'b0;
        #1;
        chk("abort_txSend", txSend, 0);
        chk("abort_busy", busy, 0);
        chk("abort_txData", txData, 0);
        chk("abort_grant", grant, 0);
        @(negedge clock);
        reset_n = 1'b1;
        model_last = NSRC - 1;
        step();
        exp_q = {8'h7E, 8'h08, 8'h01, 8'h10, 8'h10, 8'h02, 8'hB0, 8'h04, 8'h00, 8'h00, 8'h20, 8'h7E};
        run_frame("after_rst", 1'b0, 1'b0, 1'b0, 4'b0010);

        apply_reset();
        req = 4'b1111;
        for (int k = 0; k < NSRC; k++) begin
            srcAppId[k*16 +: 16] = 16'($urandom);
            srcData[k*32 +: 32]  = $urandom;
        end
        for (int k = 0; k < 4; k++) begin
`ifdef FPORT_TLM_ROUND_ROBIN_EN
            eg = NSRC'(1 << k);
`else
            eg = NSRC'(1);
`endif
            pick = model_pick(req);
            model_frame(pick);
            run_frame($sformatf("arb%0d", k), 1'b0, 1'b0, 1'b0, eg);
            model_last = pick;
        end

        for (int k = 0; k < 6; k++) begin
            req = NSRC'($urandom);
            for (int j = 0; j < NSRC; j++) begin
                srcAppId[j*16 +: 16] = 16'($urandom);
                srcData[j*32 +: 32]  = $urandom;
                if ($urandom_range(0, 1) == 1)
                    srcData[j*32 + 8*$urandom_range(0, 3) +: 8] = ($urandom_range(0, 1) == 1) ? 8'h7D : 8'h7E;
            end
            pick = model_pick(req);
            model_frame(pick);
            eg = (pick >= 0) ? NSRC'(1 << pick) : '0;
            run_frame($sformatf("rnd%0d", k), 1'b1, k[0], 1'b1, eg);
            if (pick >= 0) model_last = pick;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
